// File: rtl/btn_debounce_bank_if.sv
// Button bank bundle: raw active-high button inputs plus the debounced
// level and press-tick outputs, one bit per channel.
interface btn_debounce_bank_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] db_level;
    logic [N_BTN-1:0] db_tick;

    modport master (
        output btn,
        input  db_level,
        input  db_tick
    );

    modport slave (
        input  btn,
        output db_level,
        output db_tick
    );
endinterface

// File: rtl/btn_debounce_bank.sv
// Per-channel push-button debouncer: 2-flop synchroniser feeding a four-state
// stability FSM that yields a clean level and a single tick per accepted press.
module btn_debounce_bank #(
    parameter int N_BTN      = 4,
    parameter int STABLE_CYC = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic                clk,
    input  logic                reset,
    btn_debounce_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } db_state_e;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    // Two-stage synchroniser; the FSMs only ever look at sync2_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= {N_BTN{1'b0}};
            sync2_q <= {N_BTN{1'b0}};
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        db_state_e        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             tick_q;
        logic             s_s;

        assign s_s = sync2_q[gi];

        // Stability FSM: the counter runs only while the input disagrees with the
        // accepted level, and any reversion drops straight back to the settled state.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_ZERO;
                cnt_q   <= CNT_ZERO;
                level_q <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                case (state_q)
                    ST_ZERO: begin
                        if (s_s) begin
                            state_q <= ST_WAIT1;
                            cnt_q   <= CNT_RELOAD;
                        end else begin
                            state_q <= ST_ZERO;
                        end
                    end
                    ST_WAIT1: begin
                        if (!s_s) begin
                            state_q <= ST_ZERO;
                        end else if (cnt_q != CNT_ZERO) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else begin
                            state_q <= ST_ONE;
                            level_q <= 1'b1;
                            tick_q  <= 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (!s_s) begin
                            state_q <= ST_WAIT0;
                            cnt_q   <= CNT_RELOAD;
                        end else begin
                            state_q <= ST_ONE;
                        end
                    end
                    ST_WAIT0: begin
                        if (s_s) begin
                            state_q <= ST_ONE;
                        end else if (cnt_q != CNT_ZERO) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else begin
                            state_q <= ST_ZERO;
                            level_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_ZERO;
                        cnt_q   <= CNT_ZERO;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign bus.db_level[gi] = level_q;
        assign bus.db_tick[gi]  = tick_q;
    end

endmodule
